// File: rtl/dispatch_queue.sv
// Circular queue of decoded instructions dispatching up to DISP_W oldest entries per cycle
// to FXU/LSU/branch units. Define DQ_FXU_ROUND_ROBIN_EN for round-robin FXU selection.
module dispatch_queue #(
  parameter int FETCH_W   = 4,
  parameter int DISP_W    = 4,
  parameter int DEPTH     = 8,
  parameter int NUM_FXU   = 2,
  parameter int OPC_W     = 4,
  parameter int IMM_W     = 8,
  parameter int ROB_IDX_W = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FETCH_W-1:0]                 in_valid,
  input  logic [FETCH_W*OPC_W-1:0]           in_opcode_flat,
  input  logic [FETCH_W*IMM_W-1:0]           in_imm_flat,
  input  logic [FETCH_W*4-1:0]               in_rt_flat,
  input  logic [FETCH_W*2-1:0]               in_class_flat,
  output logic                               in_ready,
  input  logic                               flush,
  input  logic [ROB_IDX_W-1:0]               rob_tail_idx,
  input  logic [ROB_IDX_W:0]                 rob_free,
  input  logic [NUM_FXU-1:0]                 fxu_full,
  input  logic                               lsu_full,
  input  logic                               branch_full,
  output logic [NUM_FXU-1:0]                 fxu_valid,
  output logic [NUM_FXU*OPC_W-1:0]           fxu_opcode_flat,
  output logic [NUM_FXU*IMM_W-1:0]           fxu_imm_flat,
  output logic [NUM_FXU*4-1:0]               fxu_rt_flat,
  output logic [NUM_FXU*ROB_IDX_W-1:0]       fxu_rob_idx_flat,
  output logic                               lsu_valid,
  output logic [OPC_W-1:0]                   lsu_opcode,
  output logic [IMM_W-1:0]                   lsu_imm,
  output logic [3:0]                         lsu_rt,
  output logic [ROB_IDX_W-1:0]               lsu_rob_idx,
  output logic                               branch_valid,
  output logic [OPC_W-1:0]                   branch_opcode,
  output logic [IMM_W-1:0]                   branch_imm,
  output logic [3:0]                         branch_rt,
  output logic [ROB_IDX_W-1:0]               branch_rob_idx,
  output logic [$clog2(DISP_W+1)-1:0]        num_dispatched,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int ND_W   = $clog2(DISP_W+1);
  localparam int ENQ_W  = $clog2(FETCH_W+1);
  localparam int FXU_IW = (NUM_FXU > 1) ? $clog2(NUM_FXU) : 1;

  typedef enum logic [1:0] {CLS_FXU = 2'd0, CLS_LSU = 2'd1, CLS_BR = 2'd2, CLS_NOP = 2'd3} cls_e;

  typedef struct packed {
    logic [OPC_W-1:0]     opc;
    logic [IMM_W-1:0]     imm;
    logic [3:0]           rt;
    logic [ROB_IDX_W-1:0] rob;
  } pay_t;

  logic [OPC_W-1:0] opc_mem [DEPTH];
  logic [IMM_W-1:0] imm_mem [DEPTH];
  logic [3:0]       rt_mem  [DEPTH];
  cls_e             cls_mem [DEPTH];

  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [ND_W-1:0]    nd_q, nd_d;
  logic [NUM_FXU-1:0] fxu_valid_q, fxu_valid_d;
  pay_t [NUM_FXU-1:0] fxu_pay_q, fxu_pay_d;
  logic               lsu_valid_q, lsu_valid_d, br_valid_q, br_valid_d;
  pay_t               lsu_pay_q, lsu_pay_d, br_pay_q, br_pay_d;

  logic               enq_en;
  logic [ENQ_W-1:0]   enq_cnt;
  logic [ND_W-1:0]    issue_cnt;
  logic               scan_stop, grant, found;
  logic [PTR_W-1:0]   ent;
  pay_t               pay;
  logic [FXU_IW-1:0]  sel, cand;
  int                 cand_i, fxu_start;

`ifdef DQ_FXU_ROUND_ROBIN_EN
  logic [FXU_IW-1:0]  rr_ptr_q, rr_ptr_d, last_fxu;
  assign fxu_start = int'(rr_ptr_q);
`else
  assign fxu_start = 0;
`endif

  assign in_ready = (occ_q <= CNT_W'(DEPTH - FETCH_W));
  assign enq_en   = in_ready & ~flush;
  assign enq_cnt  = ENQ_W'($countones(in_valid));

  // NOTE: queue storage has no reset; occupancy gates every read, so stale entries never dispatch.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      for (int n = 0; n < FETCH_W; n++) begin
        if (in_valid[n]) begin
          opc_mem[tail_q + PTR_W'(n)] <= in_opcode_flat[OPC_W*n +: OPC_W];
          imm_mem[tail_q + PTR_W'(n)] <= in_imm_flat[IMM_W*n +: IMM_W];
          rt_mem[tail_q + PTR_W'(n)]  <= in_rt_flat[4*n +: 4];
          cls_mem[tail_q + PTR_W'(n)] <= cls_e'(in_class_flat[2*n +: 2]);
        end
      end
    end
  end

  // NOTE: every variable gets a default before the scan so no path leaves one unassigned (no latches).
  always_comb begin
    fxu_valid_d = '0;
    lsu_valid_d = 1'b0;
    br_valid_d  = 1'b0;
    fxu_pay_d   = fxu_pay_q;
    lsu_pay_d   = lsu_pay_q;
    br_pay_d    = br_pay_q;
    issue_cnt   = '0;
    scan_stop   = 1'b0;
    grant       = 1'b0;
    found       = 1'b0;
    ent         = '0;
    pay         = '0;
    sel         = '0;
    cand        = '0;
    cand_i      = 0;
`ifdef DQ_FXU_ROUND_ROBIN_EN
    last_fxu    = '0;
`endif
    for (int k = 0; k < DISP_W; k++) begin
      ent     = head_q + PTR_W'(k);
      pay.opc = opc_mem[ent];
      pay.imm = imm_mem[ent];
      pay.rt  = rt_mem[ent];
      pay.rob = rob_tail_idx + ROB_IDX_W'(k);
      grant   = 1'b0;
      found   = 1'b0;
      sel     = '0;
      if (!scan_stop && (k < int'(occ_q)) && (k < int'(rob_free))) begin
        case (cls_mem[ent])
          CLS_FXU: begin
            // Search starts at fxu_start and wraps; already-granted units count as busy.
            for (int j = 0; j < NUM_FXU; j++) begin
              cand_i = fxu_start + j;
              if (cand_i >= NUM_FXU) cand_i = cand_i - NUM_FXU;
              cand = FXU_IW'(cand_i);
              if (!found && !fxu_full[cand] && !fxu_valid_d[cand]) begin
                found = 1'b1;
                sel   = cand;
              end
            end
            if (found) begin
              grant            = 1'b1;
              fxu_valid_d[sel] = 1'b1;
              fxu_pay_d[sel]   = pay;
`ifdef DQ_FXU_ROUND_ROBIN_EN
              last_fxu         = sel;
`endif
            end
          end
          CLS_LSU: if (!lsu_full && !lsu_valid_d) begin
            grant       = 1'b1;
            lsu_valid_d = 1'b1;
            lsu_pay_d   = pay;
          end
          CLS_BR: if (!branch_full && !br_valid_d) begin
            grant      = 1'b1;
            br_valid_d = 1'b1;
            br_pay_d   = pay;
          end
          default: grant = 1'b1;
        endcase
      end
      if (grant) issue_cnt = issue_cnt + 1'b1;
      else       scan_stop = 1'b1;
    end

    head_d = head_q + PTR_W'(issue_cnt);
    tail_d = tail_q;
    occ_d  = occ_q - CNT_W'(issue_cnt);
    nd_d   = issue_cnt;
    if (enq_en) begin
      tail_d = tail_q + PTR_W'(enq_cnt);
      occ_d  = occ_d + CNT_W'(enq_cnt);
    end
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      occ_d       = '0;
      nd_d        = '0;
      fxu_valid_d = '0;
      lsu_valid_d = 1'b0;
      br_valid_d  = 1'b0;
    end
`ifdef DQ_FXU_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
    if (|fxu_valid_d) rr_ptr_d = (int'(last_fxu) == NUM_FXU-1) ? '0 : last_fxu + 1'b1;
`endif
  end

  // NOTE: state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      nd_q        <= '0;
      fxu_valid_q <= '0;
      fxu_pay_q   <= '0;
      lsu_valid_q <= 1'b0;
      lsu_pay_q   <= '0;
      br_valid_q  <= 1'b0;
      br_pay_q    <= '0;
`ifdef DQ_FXU_ROUND_ROBIN_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      nd_q        <= nd_d;
      fxu_valid_q <= fxu_valid_d;
      fxu_pay_q   <= fxu_pay_d;
      lsu_valid_q <= lsu_valid_d;
      lsu_pay_q   <= lsu_pay_d;
      br_valid_q  <= br_valid_d;
      br_pay_q    <= br_pay_d;
`ifdef DQ_FXU_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_FXU; i++) begin : g_fxu_out
    assign fxu_opcode_flat[OPC_W*i +: OPC_W]          = fxu_pay_q[i].opc;
    assign fxu_imm_flat[IMM_W*i +: IMM_W]             = fxu_pay_q[i].imm;
    assign fxu_rt_flat[4*i +: 4]                      = fxu_pay_q[i].rt;
    assign fxu_rob_idx_flat[ROB_IDX_W*i +: ROB_IDX_W] = fxu_pay_q[i].rob;
  end

  assign fxu_valid      = fxu_valid_q;
  assign lsu_valid      = lsu_valid_q;
  assign lsu_opcode     = lsu_pay_q.opc;
  assign lsu_imm        = lsu_pay_q.imm;
  assign lsu_rt         = lsu_pay_q.rt;
  assign lsu_rob_idx    = lsu_pay_q.rob;
  assign branch_valid   = br_valid_q;
  assign branch_opcode  = br_pay_q.opc;
  assign branch_imm     = br_pay_q.imm;
  assign branch_rt      = br_pay_q.rt;
  assign branch_rob_idx = br_pay_q.rob;
  assign num_dispatched = nd_q;
  assign occupancy      = occ_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: a queue-level reference model predicts each dispatch
// bundle; a monitor compares whatever the DUT presents against the predictions in order.
module tb_dispatch_queue;
  localparam int FETCH_W = 4, DISP_W = 4, DEPTH = 8, NUM_FXU = 2;
  localparam int OPC_W = 4, IMM_W = 8, ROB_IDX_W = 4;
`ifdef DQ_FXU_ROUND_ROBIN_EN
  localparam bit USE_RR = 1'b1;
`else
  localparam bit USE_RR = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [FETCH_W-1:0]           in_valid = '0;
  logic [FETCH_W*OPC_W-1:0]     in_opcode_flat = '0;
  logic [FETCH_W*IMM_W-1:0]     in_imm_flat = '0;
  logic [FETCH_W*4-1:0]         in_rt_flat = '0;
  logic [FETCH_W*2-1:0]         in_class_flat = '0;
  logic                         in_ready;
  logic                         flush = 1'b0;
  logic [ROB_IDX_W-1:0]         rob_tail_idx = '0;
  logic [ROB_IDX_W:0]           rob_free = 5'd16;
  logic [NUM_FXU-1:0]           fxu_full = '0;
  logic                         lsu_full = 1'b0, branch_full = 1'b0;
  logic [NUM_FXU-1:0]           fxu_valid;
  logic [NUM_FXU*OPC_W-1:0]     fxu_opcode_flat;
  logic [NUM_FXU*IMM_W-1:0]     fxu_imm_flat;
  logic [NUM_FXU*4-1:0]         fxu_rt_flat;
  logic [NUM_FXU*ROB_IDX_W-1:0] fxu_rob_idx_flat;
  logic                         lsu_valid, branch_valid;
  logic [OPC_W-1:0]             lsu_opcode, branch_opcode;
  logic [IMM_W-1:0]             lsu_imm, branch_imm;
  logic [3:0]                   lsu_rt, branch_rt;
  logic [ROB_IDX_W-1:0]         lsu_rob_idx, branch_rob_idx;
  logic [2:0]                   num_dispatched;
  logic [3:0]                   occupancy;

  dispatch_queue #(
    .FETCH_W(FETCH_W), .DISP_W(DISP_W), .DEPTH(DEPTH), .NUM_FXU(NUM_FXU),
    .OPC_W(OPC_W), .IMM_W(IMM_W), .ROB_IDX_W(ROB_IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode_flat(in_opcode_flat),
    .in_imm_flat(in_imm_flat), .in_rt_flat(in_rt_flat), .in_class_flat(in_class_flat),
    .in_ready(in_ready), .flush(flush), .rob_tail_idx(rob_tail_idx), .rob_free(rob_free),
    .fxu_full(fxu_full), .lsu_full(lsu_full), .branch_full(branch_full),
    .fxu_valid(fxu_valid), .fxu_opcode_flat(fxu_opcode_flat), .fxu_imm_flat(fxu_imm_flat),
    .fxu_rt_flat(fxu_rt_flat), .fxu_rob_idx_flat(fxu_rob_idx_flat),
    .lsu_valid(lsu_valid), .lsu_opcode(lsu_opcode), .lsu_imm(lsu_imm), .lsu_rt(lsu_rt),
    .lsu_rob_idx(lsu_rob_idx), .branch_valid(branch_valid), .branch_opcode(branch_opcode),
    .branch_imm(branch_imm), .branch_rt(branch_rt), .branch_rob_idx(branch_rob_idx),
    .num_dispatched(num_dispatched), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OPC_W-1:0] opc; logic [IMM_W-1:0] imm; logic [3:0] rt; logic [1:0] cls;
  } ent_t;
  typedef struct packed {
    logic [OPC_W-1:0] opc; logic [IMM_W-1:0] imm; logic [3:0] rt; logic [ROB_IDX_W-1:0] rob;
  } pay_t;
  typedef struct packed {
    logic [NUM_FXU-1:0] fv; pay_t [NUM_FXU-1:0] fp;
    logic lv; pay_t lp; logic bv; pay_t bp; logic [2:0] num;
  } exp_t;

  ent_t mq[$];
  exp_t eq[$];
  int   m_rr = 0;
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: instructions live in a plain queue; dispatch takes the oldest ones in order.
  task automatic model_step(output int issued);
    exp_t e; ent_t x; pay_t p; logic [NUM_FXU-1:0] used;
    int sz, avail, start, u, last; bit stop, ok, ready;
    e = '0; issued = 0; used = '0; last = -1; stop = 1'b0;
    if (rst) begin mq.delete(); m_rr = 0; return; end
    if (flush) begin mq.delete(); return; end
    sz = mq.size();
    ready = (sz <= DEPTH - FETCH_W);
    avail = (sz < DISP_W) ? sz : DISP_W;
    for (int k = 0; k < avail && !stop; k++) begin
      x = mq[k]; ok = 1'b0;
      p.opc = x.opc; p.imm = x.imm; p.rt = x.rt; p.rob = rob_tail_idx + ROB_IDX_W'(k);
      if (k < int'(rob_free)) begin
        case (x.cls)
          2'd0: begin
            start = USE_RR ? m_rr : 0;
            for (int j = 0; j < NUM_FXU && !ok; j++) begin
              u = (start + j) % NUM_FXU;
              if (!fxu_full[u] && !used[u]) begin
                ok = 1'b1; used[u] = 1'b1; e.fv[u] = 1'b1; e.fp[u] = p; last = u;
              end
            end
          end
          2'd1: if (!lsu_full && !e.lv) begin ok = 1'b1; e.lv = 1'b1; e.lp = p; end
          2'd2: if (!branch_full && !e.bv) begin ok = 1'b1; e.bv = 1'b1; e.bp = p; end
          default: ok = 1'b1;
        endcase
      end
      if (ok) issued++; else stop = 1'b1;
    end
    if (USE_RR && last >= 0) m_rr = (last + 1) % NUM_FXU;
    repeat (issued) void'(mq.pop_front());
    if (ready) begin
      for (int n = 0; n < FETCH_W; n++) begin
        if (in_valid[n]) begin
          x.opc = in_opcode_flat[OPC_W*n +: OPC_W];
          x.imm = in_imm_flat[IMM_W*n +: IMM_W];
          x.rt  = in_rt_flat[4*n +: 4];
          x.cls = in_class_flat[2*n +: 2];
          mq.push_back(x);
        end
      end
    end
    e.num = 3'(issued);
    if (issued > 0) eq.push_back(e);
  endtask

  // One clock: predict, take the edge, track the ROB tail, check occupancy and in_ready.
  task automatic cycle();
    int issued;
    model_step(issued);
    @(posedge clk); #1;
    rob_tail_idx = rob_tail_idx + ROB_IDX_W'(issued);
    in_valid = '0;
    flush = 1'b0;
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'(mq.size() <= DEPTH - FETCH_W));
  endtask

  task automatic set_lane(input int n, input logic [1:0] cls, input logic [3:0] rt);
    in_valid[n] = 1'b1;
    in_opcode_flat[OPC_W*n +: OPC_W] = OPC_W'($urandom);
    in_imm_flat[IMM_W*n +: IMM_W]    = IMM_W'($urandom);
    in_rt_flat[4*n +: 4]             = rt;
    in_class_flat[2*n +: 2]          = cls;
  endtask

  function automatic pay_t dut_fxu(input int i);
    pay_t p;
    p.opc = fxu_opcode_flat[OPC_W*i +: OPC_W];
    p.imm = fxu_imm_flat[IMM_W*i +: IMM_W];
    p.rt  = fxu_rt_flat[4*i +: 4];
    p.rob = fxu_rob_idx_flat[ROB_IDX_W*i +: ROB_IDX_W];
    return p;
  endfunction

  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if ((|fxu_valid) || lsu_valid || branch_valid || (num_dispatched != 3'd0)) begin
        if (eq.size() == 0) begin
          check("unexpected_dispatch", 64'({fxu_valid, lsu_valid, branch_valid, num_dispatched}), 64'(0));
        end else begin
          e = eq.pop_front();
          check("num_dispatched", 64'(num_dispatched), 64'(e.num));
          check("fxu_valid", 64'(fxu_valid), 64'(e.fv));
          check("lsu_valid", 64'(lsu_valid), 64'(e.lv));
          check("branch_valid", 64'(branch_valid), 64'(e.bv));
          for (int i = 0; i < NUM_FXU; i++)
            if (e.fv[i]) check($sformatf("fxu%0d_payload", i), 64'(dut_fxu(i)), 64'(e.fp[i]));
          if (e.lv) check("lsu_payload", 64'({lsu_opcode, lsu_imm, lsu_rt, lsu_rob_idx}), 64'(e.lp));
          if (e.bv) check("branch_payload",
                          64'({branch_opcode, branch_imm, branch_rt, branch_rob_idx}), 64'(e.bp));
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    // Reset and reset-state values.
    rst = 1'b1; cycle(); cycle();
    rst = 1'b0; mon_en = 1'b1;
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_valids", 64'({fxu_valid, lsu_valid, branch_valid}), 64'(0));
    check("rst_num_dispatched", 64'(num_dispatched), 64'(0));
    check("rst_fxu_payload", 64'({fxu_opcode_flat, fxu_imm_flat, fxu_rt_flat, fxu_rob_idx_flat}), 64'(0));
    check("rst_lsu_br_payload", 64'({lsu_opcode, lsu_imm, lsu_rt, lsu_rob_idx,
                                     branch_opcode, branch_imm, branch_rt, branch_rob_idx}), 64'(0));

    // Four FXU ops with ROB index wrap from 14.
    rob_tail_idx = 4'd14;
    for (int l = 0; l < 4; l++) set_lane(l, 2'd0, 4'(l + 1));
    cycle();
    cycle();
    check("wrap_fxu_valid", 64'(fxu_valid), 64'(2'b11));
    check("wrap_rob_first", 64'(fxu_rob_idx_flat), 64'(8'hFE));
    cycle();
    check("wrap_rob_second", 64'(fxu_rob_idx_flat), 64'(8'h10));
    check("wrap_num", 64'(num_dispatched), 64'(2));
    cycle(); cycle();

    // FXU, branch, branch, LSU: second branch blocks the scan.
    set_lane(0, 2'd0, 4'd5); set_lane(1, 2'd2, 4'd6); set_lane(2, 2'd2, 4'd7); set_lane(3, 2'd1, 4'd8);
    cycle();
    cycle();
    check("mix_occupancy", 64'(occupancy), 64'(2));
    check("mix_num", 64'(num_dispatched), 64'(2));
    check("mix_units", 64'({fxu_valid, lsu_valid, branch_valid}), 64'(4'b0101));
    cycle(); cycle(); cycle();

    // Fill with branches while the branch unit is full.
    branch_full = 1'b1;
    for (int l = 0; l < 4; l++) set_lane(l, 2'd2, 4'(l));
    cycle();
    for (int l = 0; l < 4; l++) set_lane(l, 2'd2, 4'(l + 4));
    cycle();
    check("full_occupancy", 64'(occupancy), 64'(8));
    check("full_in_ready", 64'(in_ready), 64'(0));
    for (int l = 0; l < 4; l++) set_lane(l, 2'd0, 4'd9);
    cycle();
    check("full_no_branch", 64'(branch_valid), 64'(0));
    branch_full = 1'b0;
    repeat (4) cycle();
    check("drain_in_ready", 64'(in_ready), 64'(1));
    repeat (5) cycle();

    // rob_free=1 throttles NOPs to one per cycle.
    rob_free = 5'd1;
    for (int l = 0; l < 3; l++) set_lane(l, 2'd3, 4'(l));
    cycle();
    cycle();
    check("nop_num", 64'(num_dispatched), 64'(1));
    cycle(); cycle(); cycle();
    rob_free = 5'd16;

    // Flush in the same cycle as a full-width enqueue.
    fxu_full = 2'b11;
    set_lane(0, 2'd0, 4'd1); set_lane(1, 2'd0, 4'd2);
    cycle();
    for (int l = 0; l < 4; l++) set_lane(l, 2'd0, 4'(l));
    flush = 1'b1;
    cycle();
    check("flush_occupancy", 64'(occupancy), 64'(0));
    check("flush_valids", 64'({fxu_valid, lsu_valid, branch_valid, num_dispatched}), 64'(0));
    fxu_full = '0;
    cycle(); cycle();

    // Single FXU ops on consecutive cycles from a fresh reset.
    rst = 1'b1; cycle(); rst = 1'b0;
    set_lane(0, 2'd0, 4'd1); cycle();
    set_lane(0, 2'd0, 4'd2); cycle();
    check("fxu_grant_0", 64'(fxu_valid), 64'(2'b01));
    set_lane(0, 2'd0, 4'd3); cycle();
    check("fxu_grant_1", 64'(fxu_valid), 64'(USE_RR ? 2'b10 : 2'b01));
    cycle();
    check("fxu_grant_2", 64'(fxu_valid), 64'(2'b01));
    cycle();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      n = $urandom_range(0, 4);
      for (int l = 0; l < n; l++) set_lane(l, 2'($urandom_range(0, 3)), 4'($urandom));
      fxu_full    = NUM_FXU'($urandom);
      lsu_full    = ($urandom_range(0, 3) == 0);
      branch_full = ($urandom_range(0, 3) == 0);
      rob_free    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 4)) : 5'd16;
      flush       = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      cycle();
      rst = 1'b0;
    end

    fxu_full = '0; lsu_full = 1'b0; branch_full = 1'b0; rob_free = 5'd16;
    repeat (10) cycle();
    check("scoreboard_drained", 64'(eq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor of the 4-wide instruction buffer: a DEPTH-entry circular queue of decoded instructions between fetch/decode and the functional-unit reservation stations.
- Each cycle it dispatches up to DISP_W oldest entries in program order to NUM_FXU fixed-point units, one LSU and one branch unit, and allocates consecutive ROB indices.
- Dispatch stops at the first entry that cannot issue.
- Dispatch outputs are registered. Queue flush is supported for mispredict recovery.

Parameters:
- FETCH_W, 4, max instructions enqueued per cycle (lanes).
- DISP_W, 4, max instructions dispatched per cycle; DISP_W <= DEPTH.
- DEPTH, 8, queue entries; power of 2, >= FETCH_W.
- NUM_FXU, 2, number of FXU dispatch ports.
- OPC_W, 4, opcode width.
- IMM_W, 8, immediate width.
- ROB_IDX_W, 4, ROB index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  FETCH_W  per-lane valid; contiguous from lane 0 (mask 4'b0011 legal, 4'b0101 illegal).
- in_opcode_flat  in  FETCH_W*OPC_W  lane n at [OPC_W*n +: OPC_W].
- in_imm_flat  in  FETCH_W*IMM_W  immediates.
- in_rt_flat  in  FETCH_W*4  destination registers.
- in_class_flat  in  FETCH_W*2  per-lane class: 0 FXU, 1 LSU, 2 branch, 3 NOP.
- in_ready  out  1  high when free entries >= FETCH_W.
- flush  in  1  discard all queued entries.
- rob_tail_idx  in  ROB_IDX_W  next free ROB index.
- rob_free  in  ROB_IDX_W+1  free ROB entries.
- fxu_full  in  NUM_FXU  per-FXU reservation station full.
- lsu_full  in  1  LSU full.
- branch_full  in  1  branch unit full.
- fxu_valid  out  NUM_FXU  registered dispatch strobes.
- fxu_opcode_flat / fxu_imm_flat / fxu_rt_flat / fxu_rob_idx_flat  out  NUM_FXU*{OPC_W,IMM_W,4,ROB_IDX_W}  FXU payloads.
- lsu_valid, lsu_opcode, lsu_imm, lsu_rt, lsu_rob_idx  out  1/OPC_W/IMM_W/4/ROB_IDX_W  LSU dispatch.
- branch_valid, branch_opcode, branch_imm, branch_rt, branch_rob_idx  out  as LSU  branch dispatch.
- num_dispatched  out  $clog2(DISP_W+1)  registered count of entries dispatched, incl. NOPs; the ROB advances its tail by this amount.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset: head=tail=occupancy=0; all *_valid=0; num_dispatched=0; payload outputs 0; in_ready=1 the cycle after reset deasserts.
- Enqueue: when in_ready & ~flush, lanes with in_valid are written at tail..tail+k-1 (mod DEPTH); tail += popcount(in_valid).
- in_ready is computed from the current occupancy only; same-cycle dequeue does not raise it.
- Dispatch scan: candidates are entries head+k, k=0..min(occupancy,DISP_W)-1, in order. Entry k issues only if:
  - all entries older than k issue this cycle;
  - k < rob_free;
  - its class has an unclaimed, not-full unit:
    - FXU: lowest-index FXU with ~fxu_full not already claimed this cycle.
    - LSU/branch: at most one each per cycle, and only if not full.
    - NOP: always issues; it consumes a ROB index but drives no unit.
- The first failing entry stops the scan.
- ROB index of entry k = rob_tail_idx + k, wrapping mod 2^ROB_IDX_W.
- Issued payloads appear on the unit outputs the next cycle with valid=1. Units not granted drive valid=0; their payload is don't-care and held.
- head += issued count (mod DEPTH); occupancy += enq - deq in the same cycle.
- Simultaneous enqueue and dequeue are legal. An enqueue into an empty queue is not visible to dispatch until the following cycle (minimum latency 2 cycles, enqueue to *_valid).
- flush: next cycle head=tail=occupancy=0, all *_valid=0, num_dispatched=0. Enqueue and dispatch in the flush cycle are dropped. flush has priority over rst only in the sense that both clear state; rst additionally clears payloads.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full is indicated by occupancy==DEPTH, not by pointer equality.
- rst asserted mid-operation discards all entries; in-flight registered outputs are cleared the next cycle.

Optional Feature:
- Macro DQ_FXU_ROUND_ROBIN_EN.
- Defined: a registered pointer rr_ptr (reset 0) selects the FXU search start. FXU claims search ~fxu_full starting at rr_ptr, wrapping. After any cycle with at least one FXU grant, rr_ptr = (index of last FXU granted + 1) mod NUM_FXU.
- Undefined: fixed lowest-index-first FXU priority; no rr_ptr register.

Test Plan:
- Reset, then enqueue 4 FXU ops (rt 1..4), rob_tail_idx=14, rob_free=16, no units full -> 2 cycles later fxu_valid=2'b11 with rob_idx 14,15; next cycle rob_idx 0,1 (wrap); num_dispatched=2 each cycle.
- Classes {FXU, branch, branch, LSU}, all units free -> FXU and branch issue; second branch blocks; num_dispatched=2; occupancy 4->2.
- Fill 8 entries with branch_full=1 -> in_ready=0 at occupancy 8, no branch_valid; release branch_full -> one branch per cycle; in_ready returns to 1 when occupancy <= 4.
- rob_free=1 with 3 NOPs queued -> num_dispatched=1 per cycle, rob_idx increments by 1.
- flush asserted the same cycle as in_valid=4'b1111 -> next cycle occupancy=0, all valids 0, the new lanes are not stored.
- With DQ_FXU_ROUND_ROBIN_EN: single FXU ops on consecutive cycles, no FXU full -> grants alternate FXU0, FXU1, FXU0. Without the macro -> FXU0 every cycle.
